fir: RTL and testbench
======================

FIR -- requirements
Module: fir

Interface
REQ-001 clk input 1: single clock; all state updates on the rising edge.
REQ-002 rst_n input 1: asynchronous, active-low reset.
REQ-003 x4k input 16 signed: sample x(4k), the oldest of the current 4-sample block.
REQ-004 x4k_1 input 16 signed: sample x(4k+1).
REQ-005 x4k_2 input 16 signed: sample x(4k+2).
REQ-006 x4k_3 input 16 signed: sample x(4k+3), the newest of the block.
REQ-007 y4k output 16 signed: y(4k), registered.
REQ-008 y4k_1 / y4k_2 / y4k_3 output 16 signed each: y(4k+1) / y(4k+2) / y(4k+3), registered.

Function
REQ-009 The block SHALL be a 4-parallel, 16-tap FIR: y(n) = sum over i=0..15 of h[i]*x(n-i), with x(m)=0 for samples before reset release.
REQ-010 Coefficients SHALL be fixed Q1.15: h[0..15] = 328, -512, 1024, -1536, 2048, 4096, 6144, 8192, 8192, 6144, 4096, 2048, -1536, 1024, -512, 328.
REQ-011 Samples and outputs SHALL be Q1.15 two's complement.
REQ-012 Products and sums SHALL be exact in an accumulator of at least 36 bits.
REQ-013 Each output SHALL be the accumulator arithmetic-shifted right by 15 (floor), then narrowed to 16 bits per REQ-020.
REQ-014 Implementation SHALL use the fast FIR algorithm: two cascaded 2-parallel FFA stages giving 9 length-4 sub-filters.
REQ-015 FFA input pre-adds SHALL widen to 18 bits; pre-added coefficients SHALL widen to 18 bits.
REQ-016 Results SHALL be bit-identical to the direct form of REQ-009 and REQ-013.
REQ-017 A new input block SHALL be accepted every clock; there is no handshake or stall.
REQ-018 Latency SHALL be 2 cycles: the block present before edge t is registered at edge t, and its outputs are valid after edge t+1 until edge t+2.
REQ-019 Sub-filter delay lines SHALL advance by one block per clock.

Reset
REQ-020 Narrowing SHALL follow Configuration; reset SHALL clear all input registers, sub-filter delay lines, post-add delay elements and output registers to 0.
REQ-021 While rst_n=0 all outputs SHALL be 0.
REQ-022 Reset asserted mid-stream SHALL discard all history; after release, outputs SHALL match a filter started from all-zero state.

Configuration
REQ-023 Macro FIR_SAT_EN defined: outputs outside [-32768, 32767] SHALL saturate to the nearest bound.
REQ-024 Macro FIR_SAT_EN undefined: outputs SHALL take the low 16 bits (two's-complement wrap).

Structure
REQ-025 Package fir_pkg SHALL hold the data width (16), the coefficient width (16), the accumulator width (36), the tap count (16), the parallelism (4), the h[] constant array and the pre-added coefficient arrays.
REQ-026 One sub-module fir_sub4 SHALL implement a length-4, 18-bit-input, registered-delay sub-filter with the coefficient set as a parameter.
REQ-027 fir SHALL contain 9 instances of fir_sub4, plus the pre-add, post-add and registers.

Verification
REQ-028 Impulse test: x(0)=16384, all other samples 0 -> y(0..15) = 164, -256, 512, -768, 1024, 2048, 3072, 4096, 4096, 3072, 2048, 1024, -768, 512, -256, 164, then 0.
REQ-029 Step test, +32767 on every sample -> steady-state output 32767 with FIR_SAT_EN, or -25970 without it (unclamped 39566).
REQ-030 Step test, -32768 on every sample -> steady-state output -32768 with FIR_SAT_EN, or 25968 without it.
REQ-031 Latency check: an impulse on x4k_2 at edge t -> 164 on y4k_2 after edge t+1, -256 on y4k_3, then 512 on y4k of the next block.
REQ-032 Reset mid-stream: random stream, rst_n pulsed low for 1 cycle -> outputs 0 during reset, then match a golden model restarted from zero.
REQ-033 Random test: 10000 blocks of random 16-bit samples -> every output matches the direct-form golden model of REQ-009 and REQ-013 bit-exactly.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, coefficient tables and arithmetic helpers for the 4-parallel FFA FIR.
// Output narrowing depends on FIR_SAT_EN: defined saturates, undefined wraps.
package fir_pkg;

   localparam int DATA_W  = 16;
   localparam int COEF_W  = 16;
   localparam int ACC_W   = 36;
   localparam int TAPS    = 16;
   localparam int PAR     = 4;
   localparam int PRE_W   = 18;
   localparam int SUB_LEN = TAPS / PAR;
   localparam int N_SUB   = 9;
   localparam int SHIFT   = 15;
   localparam int SAT_MAX = 2 ** (DATA_W - 1) - 1;
   localparam int SAT_MIN = -(2 ** (DATA_W - 1));

   typedef logic signed [DATA_W-1:0]  sample_t;
   typedef logic signed [PRE_W-1:0]   pre_t;
   typedef logic signed [ACC_W-1:0]   acc_t;
   typedef logic [SUB_LEN*PRE_W-1:0]  coef_set_t;
   typedef logic [PAR-1:0]            phase_mask_t;
   typedef logic [PAR*DATA_W-1:0]     block_t;

   localparam logic signed [COEF_W-1:0] H [TAPS] = '{
      16'sd328,  -16'sd512,  16'sd1024, -16'sd1536,
      16'sd2048,  16'sd4096, 16'sd6144,  16'sd8192,
      16'sd8192,  16'sd6144, 16'sd4096,  16'sd2048,
      -16'sd1536, 16'sd1024, -16'sd512,  16'sd328
   };

   // Polyphase combination per sub-filter (bit j selects phase j):
   // H0, H2, H0+H2, H1, H3, H1+H3, H0+H1, H2+H3, H0+H1+H2+H3.
   localparam phase_mask_t SUB_MASK [N_SUB] = '{
      4'b0001, 4'b0100, 4'b0101,
      4'b0010, 4'b1000, 4'b1010,
      4'b0011, 4'b1100, 4'b1111
   };

   function automatic coef_set_t sub_coefs(phase_mask_t mask);
      coef_set_t set;
      pre_t      sum;
      set = '0;
      for (int k = 0; k < SUB_LEN; k++) begin
         sum = '0;
         for (int j = 0; j < PAR; j++)
            if (mask[j]) sum = sum + pre_t'(H[PAR*k + j]);
         set[k*PRE_W +: PRE_W] = sum;
      end
      return set;
   endfunction

   localparam coef_set_t SUB_COEF [N_SUB] = '{
      sub_coefs(SUB_MASK[0]), sub_coefs(SUB_MASK[1]), sub_coefs(SUB_MASK[2]),
      sub_coefs(SUB_MASK[3]), sub_coefs(SUB_MASK[4]), sub_coefs(SUB_MASK[5]),
      sub_coefs(SUB_MASK[6]), sub_coefs(SUB_MASK[7]), sub_coefs(SUB_MASK[8])
   };

   function automatic pre_t pre_add(phase_mask_t mask, block_t blk);
      pre_t sum;
      sum = '0;
      for (int j = 0; j < PAR; j++)
         if (mask[j]) sum = sum + pre_t'(sample_t'(blk[j*DATA_W +: DATA_W]));
      return sum;
   endfunction

   function automatic sample_t narrow(acc_t acc);
      logic signed [ACC_W-SHIFT-1:0] q;
      q = acc[ACC_W-1:SHIFT];
`ifdef FIR_SAT_EN
      if (q > SAT_MAX)
         return sample_t'(SAT_MAX);
      else if (q < SAT_MIN)
         return sample_t'(SAT_MIN);
      else
         return q[DATA_W-1:0];
`else
      return q[DATA_W-1:0];
`endif
   endfunction

endpackage

// File: rtl/fir_sub4.sv
// Length-4 sub-filter on 18-bit pre-added inputs; the delay line advances one block per clock
// and the output is combinational from the current input plus the three stored taps.
module fir_sub4
   import fir_pkg::*;
#(
   parameter coef_set_t COEF = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [PRE_W-1:0] u,
   output logic signed [ACC_W-1:0] s
);

   logic signed [PRE_W-1:0] dly_reg [SUB_LEN-1];
   logic signed [PRE_W-1:0] tap     [SUB_LEN];
   logic signed [ACC_W-1:0] prod    [SUB_LEN];
   logic signed [ACC_W-1:0] acc;

   assign tap[0] = u;

   generate
      for (genvar gi = 1; gi < SUB_LEN; gi++) begin : g_tap
         assign tap[gi] = dly_reg[gi-1];
      end
      for (genvar gi = 0; gi < SUB_LEN; gi++) begin : g_mul
         localparam logic signed [PRE_W-1:0] G = COEF[gi*PRE_W +: PRE_W];
         assign prod[gi] = acc_t'(G) * acc_t'(tap[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SUB_LEN-1; k++) dly_reg[k] <= '0;
      end else begin
         dly_reg[0] <= u;
         for (int k = 1; k < SUB_LEN-1; k++) dly_reg[k] <= dly_reg[k-1];
      end
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < SUB_LEN; k++) acc = acc + prod[k];
   end

   assign s = acc;

endmodule

// File: rtl/fir.sv
// 4-parallel 16-tap FIR built from two cascaded 2-parallel fast-FIR stages (9 sub-filters).
// Narrowing is set by FIR_SAT_EN (saturate when defined, wrap otherwise).
module fir
   import fir_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] x4k,
   input  logic signed [15:0] x4k_1,
   input  logic signed [15:0] x4k_2,
   input  logic signed [15:0] x4k_3,
   output logic signed [15:0] y4k,
   output logic signed [15:0] y4k_1,
   output logic signed [15:0] y4k_2,
   output logic signed [15:0] y4k_3
);

   block_t                  x_reg;
   logic signed [PRE_W-1:0] u [N_SUB];
   logic signed [ACC_W-1:0] s [N_SUB];

   logic signed [ACC_W-1:0] s2_dly_reg, s5_dly_reg, s8_dly_reg, bxo_o_dly_reg;
   logic signed [ACC_W-1:0] axe_e, axe_o, bxo_e, bxo_o, m_e, m_o;
   logic signed [ACC_W-1:0] y_acc [PAR];
   logic signed [DATA_W-1:0] y_reg [PAR];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) x_reg <= '0;
      else        x_reg <= {x4k_3, x4k_2, x4k_1, x4k};
   end

   generate
      for (genvar gi = 0; gi < N_SUB; gi++) begin : g_sub
         assign u[gi] = pre_add(SUB_MASK[gi], x_reg);
         fir_sub4 #(.COEF(SUB_COEF[gi])) u_sub (
            .clk   (clk),
            .rst_n (rst_n),
            .u     (u[gi]),
            .s     (s[gi])
         );
      end
   endgenerate

   // Inner stage: even part = P0Q0 + delayed P1Q1, odd part = cross term minus both.
   // All post-adds are modulo 2^36; the true outputs fit, so the result stays exact.
   always_comb begin
      axe_e = s[0] + s2_dly_reg;
      axe_o = s[2] - s[0] - s[1];
      bxo_e = s[3] + s5_dly_reg;
      bxo_o = s[5] - s[3] - s[4];
      m_e   = s[6] + s8_dly_reg;
      m_o   = s[8] - s[6] - s[7];
      y_acc[0] = axe_e + bxo_o_dly_reg;
      y_acc[1] = m_e - axe_e - bxo_e;
      y_acc[2] = axe_o + bxo_e;
      y_acc[3] = m_o - axe_o - bxo_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_dly_reg    <= '0;
         s5_dly_reg    <= '0;
         s8_dly_reg    <= '0;
         bxo_o_dly_reg <= '0;
         for (int k = 0; k < PAR; k++) y_reg[k] <= '0;
      end else begin
         s2_dly_reg    <= s[1];
         s5_dly_reg    <= s[4];
         s8_dly_reg    <= s[7];
         bxo_o_dly_reg <= bxo_o;
         for (int k = 0; k < PAR; k++) y_reg[k] <= narrow(y_acc[k]);
      end
   end

   assign y4k   = y_reg[0];
   assign y4k_1 = y_reg[1];
   assign y4k_2 = y_reg[2];
   assign y4k_3 = y_reg[3];

endmodule

// File: tb/tb_fir.sv
// Scoreboard bench for fir: driver pushes expected blocks, monitor pops two cycles later.
// Expectations follow FIR_SAT_EN the same way the design does.
module tb_fir;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] x4k = '0, x4k_1 = '0, x4k_2 = '0, x4k_3 = '0;
   logic signed [15:0] y4k, y4k_1, y4k_2, y4k_3;
   logic signed [15:0] y_act [4];

   typedef struct packed {
      logic        chk;
      logic [63:0] y;
   } sb_t;

   sb_t  sb [$];
   int   hist [$];
   bit   drv_active = 1'b0;
   bit   pending = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   localparam int H_TB [16] = '{328, -512, 1024, -1536, 2048, 4096, 6144, 8192,
                                8192, 6144, 4096, 2048, -1536, 1024, -512, 328};
`ifdef FIR_SAT_EN
   localparam int STEP_P = 32767;
   localparam int STEP_N = -32768;
`else
   localparam int STEP_P = -25970;
   localparam int STEP_N = 25968;
`endif

   fir dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x4k   (x4k),
      .x4k_1 (x4k_1),
      .x4k_2 (x4k_2),
      .x4k_3 (x4k_3),
      .y4k   (y4k),
      .y4k_1 (y4k_1),
      .y4k_2 (y4k_2),
      .y4k_3 (y4k_3)
   );

   always #5 clk = ~clk;

   assign y_act[0] = y4k;
   assign y_act[1] = y4k_1;
   assign y_act[2] = y4k_2;
   assign y_act[3] = y4k_3;

   function automatic logic [63:0] pack4(int a, int b, int c, int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   // Direct-form reference: newest sample at index 0.
   task automatic model_step(input int xin, output logic [15:0] yout);
      longint acc;
      longint q;
      hist.push_front(xin);
      if (hist.size() > 16) void'(hist.pop_back());
      acc = 0;
      for (int i = 0; i < hist.size(); i++) acc += longint'(H_TB[i]) * longint'(hist[i]);
      q = acc >>> 15;
`ifdef FIR_SAT_EN
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
`endif
      yout = q[15:0];
   endtask

   task automatic drive(input int a, input int b, input int c, input int d,
                        input logic [63:0] exp, input bit chk);
      sb_t it;
      @(negedge clk);
      x4k = 16'(a); x4k_1 = 16'(b); x4k_2 = 16'(c); x4k_3 = 16'(d);
      drv_active = 1'b1;
      it.chk = chk;
      it.y   = exp;
      sb.push_back(it);
   endtask

   task automatic drive_model(input int a, input int b, input int c, input int d);
      logic [15:0] e0, e1, e2, e3;
      model_step(a, e0);
      model_step(b, e1);
      model_step(c, e2);
      model_step(d, e3);
      drive(a, b, c, d, {e3, e2, e1, e0}, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drv_active = 1'b0;
      x4k = 16'sh1234; x4k_1 = -16'sd777; x4k_2 = 16'sh7fff; x4k_3 = -16'sd32768;
      hist.delete();
      @(negedge clk);
      rst_n = 1'b1;
      x4k = '0; x4k_1 = '0; x4k_2 = '0; x4k_3 = '0;
   endtask

   function automatic int rnd16();
      logic signed [15:0] r;
      r = 16'($urandom);
      return int'(r);
   endfunction

   // Monitor: a block registered at edge t is compared just after edge t+1.
   initial begin
      sb_t e;
      int  blk;
      logic signed [15:0] want;
      blk = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
               n_tests++;
               if (y_act[i] !== 16'sd0) begin
                  n_fail++;
                  $display("FAIL reset_zero lane%0d: got %0d, want 0", i, y_act[i]);
               end
            end
            sb.delete();
            pending = 1'b0;
         end else begin
            if (pending) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_underflow: got output block, want none pending");
               end else begin
                  e = sb.pop_front();
                  if (e.chk) begin
                     for (int i = 0; i < 4; i++) begin
                        want = e.y[16*i +: 16];
                        n_tests++;
                        if (y_act[i] !== want) begin
                           n_fail++;
                           $display("FAIL lane%0d blk %0d: got %0d, want %0d", i, blk, y_act[i], want);
                        end
                     end
                  end
                  $display("[TB] blk %0d y=%0d,%0d,%0d,%0d", blk, y_act[0], y_act[1], y_act[2], y_act[3]);
                  blk++;
               end
            end
            pending = drv_active;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Impulse on x(4k)
      drive(16384, 0, 0, 0, pack4(164, -256, 512, -768), 1'b1);
      drive(0, 0, 0, 0, pack4(1024, 2048, 3072, 4096), 1'b1);
      drive(0, 0, 0, 0, pack4(4096, 3072, 2048, 1024), 1'b1);
      drive(0, 0, 0, 0, pack4(-768, 512, -256, 164), 1'b1);
      drive(0, 0, 0, 0, pack4(0, 0, 0, 0), 1'b1);

      // Impulse on x(4k+2): response straddles block boundaries
      drive(0, 0, 16384, 0, pack4(0, 0, 164, -256), 1'b1);
      drive(0, 0, 0, 0, pack4(512, -768, 1024, 2048), 1'b1);
      drive(0, 0, 0, 0, pack4(3072, 4096, 4096, 3072), 1'b1);
      drive(0, 0, 0, 0, pack4(2048, 1024, -768, 512), 1'b1);
      drive(0, 0, 0, 0, pack4(-256, 164, 0, 0), 1'b1);
      drive(0, 0, 0, 0, pack4(0, 0, 0, 0), 1'b1);

      // Full-scale steps; only fully-settled blocks are checked
      for (int b = 0; b < 7; b++)
         drive(32767, 32767, 32767, 32767, pack4(STEP_P, STEP_P, STEP_P, STEP_P), b >= 4);
      for (int b = 0; b < 7; b++)
         drive(-32768, -32768, -32768, -32768, pack4(STEP_N, STEP_N, STEP_N, STEP_N), b >= 4);

      // Mid-stream reset after non-zero history, then random stream vs reference
      do_reset();
      for (int b = 0; b < 10000; b++) begin
         if (b == 5000) do_reset();
         drive_model(rnd16(), rnd16(), rnd16(), rnd16());
      end

      @(negedge clk);
      drv_active = 1'b0;
      x4k = '0; x4k_1 = '0; x4k_2 = '0; x4k_3 = '0;
      for (int i = 0; i < 10 && (sb.size() != 0 || pending); i++) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d blocks outstanding, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
